writeback_stage: RTL



---
 rtl/wb_pkg.sv | 20 ++
 rtl/writeback_stage_load_align.sv | 23 ++
 rtl/writeback_stage.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/wb_pkg.sv
// Shared types and defaults for the writeback stage.
package wb_pkg;

  localparam int DATA_W  = 32;
  localparam int REG_AW  = 4;
  localparam int TIMEOUT = 16;

  localparam logic [3:0] PC_REG = 4'hF;

  typedef enum logic {
    IDLE     = 1'b0,
    MEM_WAIT = 1'b1
  } wb_state_e;

  // The timeout counter only needs to reach TIMEOUT-1; keep at least one bit.
  function automatic int cnt_width(input int timeout);
    return (timeout > 2) ? $clog2(timeout) : 1;
  endfunction

endpackage

// File: rtl/writeback_stage_load_align.sv
// Selects the addressed byte lane for byte loads; word loads pass through.
module load_align
  import wb_pkg::*;
#(
  parameter int DATA_W = wb_pkg::DATA_W
) (
  input  logic [DATA_W-1:0] rdata_i,
  input  logic [1:0]        addr_i,
  input  logic              byte_i,
  output logic [DATA_W-1:0] data_o
);

  // Byte lane select with zero-extension.
  always_comb begin
    data_o = rdata_i;
    if (byte_i) begin
      data_o = {{(DATA_W-8){1'b0}}, rdata_i[{addr_i, 3'b000} +: 8]};
    end else begin
      data_o = rdata_i;
    end
  end

endmodule

// File: rtl/writeback_stage.sv
// Final pipeline stage: retires ALU results and loads into the register file,
// diverting r15 writes to the PC port.
module writeback_stage
  import wb_pkg::*;
#(
  parameter int DATA_W  = wb_pkg::DATA_W,
  parameter int REG_AW  = wb_pkg::REG_AW,
  parameter int TIMEOUT = wb_pkg::TIMEOUT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_we,
  input  logic              in_is_load,
  input  logic              in_byte,
  input  logic [REG_AW-1:0] in_rd,
  input  logic [DATA_W-1:0] in_result,
  output logic              mem_req,
  output logic [DATA_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              we_RF,
  output logic [REG_AW-1:0] rd,
  output logic [DATA_W-1:0] WD3,
  output logic              pc_we,
  output logic [DATA_W-1:0] pc_wdata,
  output logic              pend_valid,
  output logic [REG_AW-1:0] pend_rd,
  output logic              align_err,
  output logic              mem_err
);

  localparam int CNT_W = cnt_width(TIMEOUT);
  localparam logic [REG_AW-1:0] PC_IDX = REG_AW'(PC_REG);

  wb_state_e         state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              mem_req_q, mem_req_d;
  logic [DATA_W-1:0] mem_addr_q, mem_addr_d;
  logic              we_rf_q, we_rf_d;
  logic [REG_AW-1:0] rd_q, rd_d;
  logic [DATA_W-1:0] wd3_q, wd3_d;
  logic              pc_we_q, pc_we_d;
  logic [DATA_W-1:0] pc_wdata_q, pc_wdata_d;
  logic              pend_valid_q, pend_valid_d;
  logic [REG_AW-1:0] pend_rd_q, pend_rd_d;
  logic              align_err_q, align_err_d;
  logic              mem_err_q, mem_err_d;
  logic              ld_byte_q, ld_byte_d;
  logic [1:0]        ld_off_q, ld_off_d;
  logic              ld_we_q, ld_we_d;
  logic [DATA_W-1:0] load_data_s;

  load_align #(.DATA_W(DATA_W)) u_align (
    .rdata_i (mem_rdata),
    .addr_i  (ld_off_q),
    .byte_i  (ld_byte_q),
    .data_o  (load_data_s)
  );

  assign in_ready = (state_q == IDLE);

  // Next-state and registered-output decode.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    mem_req_d    = mem_req_q;
    mem_addr_d   = mem_addr_q;
    we_rf_d      = 1'b0;
    rd_d         = rd_q;
    wd3_d        = wd3_q;
    pc_we_d      = 1'b0;
    pc_wdata_d   = pc_wdata_q;
    pend_valid_d = pend_valid_q;
    pend_rd_d    = pend_rd_q;
    align_err_d  = 1'b0;
    mem_err_d    = mem_err_q;
    ld_byte_d    = ld_byte_q;
    ld_off_d     = ld_off_q;
    ld_we_d      = ld_we_q;
    case (state_q)
      IDLE: begin
        if (in_valid && !in_is_load) begin
          if (in_we && (in_rd == PC_IDX)) begin
            pc_we_d    = 1'b1;
            pc_wdata_d = in_result;
          end else if (in_we) begin
            we_rf_d = 1'b1;
            rd_d    = in_rd;
            wd3_d   = in_result;
          end else begin
            we_rf_d = 1'b0;
          end
        end else if (in_valid && !in_byte && (in_result[1:0] != 2'b00)) begin
          align_err_d = 1'b1;
        end else if (in_valid) begin
          state_d      = MEM_WAIT;
          cnt_d        = '0;
          mem_req_d    = 1'b1;
          mem_addr_d   = {in_result[DATA_W-1:2], 2'b00};
          pend_valid_d = 1'b1;
          pend_rd_d    = in_rd;
          ld_byte_d    = in_byte;
          ld_off_d     = in_result[1:0];
          ld_we_d      = in_we;
        end else begin
          state_d = IDLE;
        end
      end
      MEM_WAIT: begin
        // An ack on the expiry cycle takes priority over the timeout.
        if (mem_ack) begin
          state_d      = IDLE;
          mem_req_d    = 1'b0;
          pend_valid_d = 1'b0;
          if (ld_we_q && (pend_rd_q == PC_IDX)) begin
            pc_we_d    = 1'b1;
            pc_wdata_d = load_data_s;
          end else if (ld_we_q) begin
            we_rf_d = 1'b1;
            rd_d    = pend_rd_q;
            wd3_d   = load_data_s;
          end else begin
            we_rf_d = 1'b0;
          end
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          state_d      = IDLE;
          mem_req_d    = 1'b0;
          pend_valid_d = 1'b0;
          mem_err_d    = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d   = IDLE;
        mem_req_d = 1'b0;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      mem_req_q    <= 1'b0;
      mem_addr_q   <= '0;
      we_rf_q      <= 1'b0;
      rd_q         <= '0;
      wd3_q        <= '0;
      pc_we_q      <= 1'b0;
      pc_wdata_q   <= '0;
      pend_valid_q <= 1'b0;
      pend_rd_q    <= '0;
      align_err_q  <= 1'b0;
      mem_err_q    <= 1'b0;
      ld_byte_q    <= 1'b0;
      ld_off_q     <= 2'b00;
      ld_we_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      mem_req_q    <= mem_req_d;
      mem_addr_q   <= mem_addr_d;
      we_rf_q      <= we_rf_d;
      rd_q         <= rd_d;
      wd3_q        <= wd3_d;
      pc_we_q      <= pc_we_d;
      pc_wdata_q   <= pc_wdata_d;
      pend_valid_q <= pend_valid_d;
      pend_rd_q    <= pend_rd_d;
      align_err_q  <= align_err_d;
      mem_err_q    <= mem_err_d;
      ld_byte_q    <= ld_byte_d;
      ld_off_q     <= ld_off_d;
      ld_we_q      <= ld_we_d;
    end
  end

  assign mem_req    = mem_req_q;
  assign mem_addr   = mem_addr_q;
  assign we_RF      = we_rf_q;
  assign rd         = rd_q;
  assign WD3        = wd3_q;
  assign pc_we      = pc_we_q;
  assign pc_wdata   = pc_wdata_q;
  assign pend_valid = pend_valid_q;
  assign pend_rd    = pend_rd_q;
  assign align_err  = align_err_q;
  assign mem_err    = mem_err_q;

endmodule
